// File: rtl/sopc_lan_pkg.sv
// Register map and EDGECAP bit positions shared by the LAN nINT conditioner.
package sopc_lan_pkg;
  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_EVCNT   = 2'd3;

  localparam int EC_ASSERT   = 0;
  localparam int EC_DEASSERT = 1;
endpackage

// File: rtl/bit_sync_filter.sv
// Synchroniser + persistence glitch filter + edge pulses for one asynchronous
// board input. Idles high, so every flop presets to 1.
module bit_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic filtered,
  output logic fall,
  output logic rise
);
  localparam logic [7:0] FC_LAST = 8'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             fcnt;
  logic                   filtered_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // filtered only follows sync after FILTER_CYCLES consecutive disagreements
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered   <= 1'b1;
      fcnt       <= '0;
      filtered_d <= 1'b1;
    end else begin
      filtered_d <= filtered;
      if (sync == filtered) begin
        fcnt <= '0;
      end else if (fcnt == FC_LAST) begin
        filtered <= sync;
        fcnt     <= '0;
      end else begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  assign fall = filtered_d & ~filtered;
  assign rise = ~filtered_d & filtered;
endmodule

// File: rtl/lan_nint_conditioner.sv
// Conditions the LAN controller's active-low nINT pin and exposes status,
// mask, edge capture and an assert-event counter over Avalon-MM, plus a CPU irq.
module lan_nint_conditioner
  import sopc_lan_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nint_raw,
  output logic        nint_clean,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  logic             sync, filtered, assert_ev, deassert_ev;
  logic             mask;
  logic [1:0]       edgecap, edgecap_nxt;
  logic [CNT_W-1:0] evcnt, evcnt_nxt;
  logic [31:0]      rd_mux;
  logic             wr_mask, wr_ec, wr_cnt;

  bit_sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt (
    .clk     (clk),
    .reset   (reset),
    .din     (nint_raw),
    .sync    (sync),
    .filtered(filtered),
    .fall    (assert_ev),
    .rise    (deassert_ev)
  );

  assign nint_clean = filtered;

  assign wr_mask = write && (address == ADDR_MASK);
  assign wr_ec   = write && (address == ADDR_EDGECAP);
  assign wr_cnt  = write && (address == ADDR_EVCNT);

  // Edge sets are OR'd in after the W1C so a coincident event survives.
  always_comb begin
    edgecap_nxt = edgecap & ~(wr_ec ? writedata[1:0] : 2'b00);
    edgecap_nxt[EC_ASSERT]   = edgecap_nxt[EC_ASSERT]   | assert_ev;
    edgecap_nxt[EC_DEASSERT] = edgecap_nxt[EC_DEASSERT] | deassert_ev;
  end

  always_comb begin
    evcnt_nxt = evcnt;
    if (assert_ev) begin
      if (wr_cnt)          evcnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (~&evcnt)    evcnt_nxt = evcnt + 1'b1;
    end else if (wr_cnt) begin
      evcnt_nxt = '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux = {30'd0, ~sync, ~filtered};
      ADDR_MASK:    rd_mux = {31'd0, mask};
      ADDR_EDGECAP: rd_mux = {30'd0, edgecap};
      ADDR_EVCNT:   rd_mux = 32'(evcnt);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask     <= 1'b0;
      edgecap  <= '0;
      evcnt    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_mask) mask <= writedata[0];
      edgecap  <= edgecap_nxt;
      evcnt    <= evcnt_nxt;
      readdata <= rd_mux;
      irq      <= mask & (edgecap[EC_ASSERT] | assert_ev);
    end
  end
endmodule

// File: tb/tb_lan_nint_conditioner.sv
// Directed checks of filtering latency, glitch rejection, edge capture,
// irq masking and counter saturation for lan_nint_conditioner.
module tb_lan_nint_conditioner;
  import sopc_lan_pkg::*;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nint_raw = 1'b1;
  logic        nint_clean;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  lan_nint_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(8), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .nint_raw  (nint_raw),
    .nint_clean(nint_clean),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    tick();
    chk(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
  endtask

  logic saw_low;

  initial begin
    // reset state
    tick(3);
    chk("rst_clean", {31'd0, nint_clean}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    reset = 1'b0;
    rd(ADDR_STATUS,  32'h0, "idle_status");
    rd(ADDR_MASK,    32'h0, "idle_mask");
    rd(ADDR_EDGECAP, 32'h0, "idle_edgecap");
    rd(ADDR_EVCNT,   32'h0, "idle_evcnt");

    // stable low: falls exactly 10 edges after first sampling edge
    nint_raw = 1'b0;
    tick(9);
    chk("lat_edge9", {31'd0, nint_clean}, 32'd1);
    tick();
    chk("lat_edge10", {31'd0, nint_clean}, 32'd0);
    tick(2);
    rd(ADDR_EDGECAP, 32'h1, "assert_edgecap");
    rd(ADDR_EVCNT,   32'h1, "assert_evcnt");
    rd(ADDR_STATUS,  32'h3, "assert_status");
    chk("assert_irq_masked", {31'd0, irq}, 32'd0);

    // release, then clear everything
    nint_raw = 1'b1;
    tick(14);
    rd(ADDR_EDGECAP, 32'h3, "deassert_edgecap");
    rd(ADDR_STATUS,  32'h0, "deassert_status");
    wr(ADDR_EDGECAP, 32'h3);
    wr(ADDR_EVCNT, 32'h0);
    rd(ADDR_EDGECAP, 32'h0, "w1c_edgecap");
    rd(ADDR_EVCNT,   32'h0, "clr_evcnt");

    // 7-cycle glitch is rejected
    nint_raw = 1'b0;
    tick(7);
    nint_raw = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!nint_clean) saw_low = 1'b1;
    end
    chk("glitch7_clean", {31'd0, saw_low}, 32'd0);
    rd(ADDR_EDGECAP, 32'h0, "glitch7_edgecap");
    rd(ADDR_EVCNT,   32'h0, "glitch7_evcnt");

    // 8-cycle pulse gets through, both edges captured
    nint_raw = 1'b0;
    tick(8);
    nint_raw = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!nint_clean) saw_low = 1'b1;
    end
    chk("pulse8_clean", {31'd0, saw_low}, 32'd1);
    rd(ADDR_EDGECAP, 32'h3, "pulse8_edgecap");
    rd(ADDR_EVCNT,   32'h1, "pulse8_evcnt");
    wr(ADDR_EDGECAP, 32'h3);
    wr(ADDR_EVCNT, 32'h0);

    // masked irq, then W1C drops it
    wr(ADDR_MASK, 32'h1);
    rd(ADDR_MASK, 32'h1, "mask_rd");
    nint_raw = 1'b0;
    tick(12);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(ADDR_EDGECAP, 32'h1);
    tick();
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // W1C coinciding with a fresh assert_ev: set wins
    nint_raw = 1'b1;
    tick(14);
    chk("irq_on_deassert", {31'd0, irq}, 32'd0);
    wr(ADDR_EDGECAP, 32'h2);
    nint_raw = 1'b0;
    tick(10);
    chk("coinc_align", {31'd0, nint_clean}, 32'd0);
    wr(ADDR_EDGECAP, 32'h1);
    tick();
    chk("coinc_irq", {31'd0, irq}, 32'd1);
    rd(ADDR_EDGECAP, 32'h1, "coinc_edgecap");

    // saturation
    wr(ADDR_EVCNT, 32'h0);
    for (int i = 0; i < 15; i++) begin
      nint_raw = 1'b1; tick(12);
      nint_raw = 1'b0; tick(12);
    end
    rd(ADDR_EVCNT, 32'hF, "evcnt_full");
    nint_raw = 1'b1; tick(12);
    nint_raw = 1'b0; tick(12);
    rd(ADDR_EVCNT, 32'hF, "evcnt_sat");

    // EVCNT write coinciding with assert_ev
    nint_raw = 1'b1; tick(12);
    nint_raw = 1'b0; tick(10);
    wr(ADDR_EVCNT, 32'h0);
    rd(ADDR_EVCNT, 32'h1, "evcnt_wr_coinc");

    // writes to STATUS ignored
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    rd(ADDR_STATUS, 32'h3, "status_ro");

    // reset mid-filter
    nint_raw = 1'b1;
    tick(14);
    nint_raw = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(2);
    chk("midrst_clean", {31'd0, nint_clean}, 32'd1);
    reset = 1'b0;
    tick(8);
    rd(ADDR_EDGECAP, 32'h0, "midrst_edgecap");
    chk("midrst_edge9", {31'd0, nint_clean}, 32'd1);
    tick();
    chk("midrst_edge10", {31'd0, nint_clean}, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
